// File: rtl/odd_even_sort_sequencer_pkg.sv
// Shared definitions for the sorter controllers: controller states and a
// constant-foldable ceil-log2 helper for counter sizing.
package odd_even_sort_sequencer_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sortState_e;

    // Smallest b with 2**b >= value; value is at least 2 for every caller.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/odd_even_sort_sequencer_compare_exchange.sv
// Unsigned compare-exchange cell: lo = min(a, b), hi = max(a, b).
// Swaps only on strict a > b, so equal keys pass through with lo taken from a.
module compare_exchange #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic swap;

    assign swap = a > b;
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/odd_even_sort_sequencer.sv
// Serial-in / serial-out batch sorter: loads N keys, runs N odd-even
// transposition phases on a shared bank of N/2 compare-exchange cells, drains ascending.
module odd_even_sort_sequencer
    import odd_even_sort_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned idxWidth  = clog2(N);
    localparam int unsigned pairCount = N / 2;
    localparam logic [idxWidth-1:0] lastIdx = idxWidth'(N - 1);

    if (N < 2 || (N % 2) != 0) begin : gBadN
        $error("odd_even_sort_sequencer: N must be even and >= 2");
    end

    sortState_e state;
    sortState_e stateNext;

    logic [idxWidth-1:0] wrIdx;
    logic [idxWidth-1:0] phase;
    logic [idxWidth-1:0] rdIdx;

    logic [WIDTH-1:0] mem      [N];
    logic [WIDTH-1:0] bankNext [N];
    logic [WIDTH-1:0] opA      [pairCount];
    logic [WIDTH-1:0] opB      [pairCount];
    logic [WIDTH-1:0] resLo    [pairCount];
    logic [WIDTH-1:0] resHi    [pairCount];

    logic accept;
    logic emit;
    logic lastPhase;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? mem[rdIdx] : '0;
    assign out_last  = out_valid && (rdIdx == lastIdx);

    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;
    assign lastPhase = (phase == lastIdx);

    // Even phases pair (2k, 2k+1); odd phases pair (2k+1, 2k+2) and leave the last cell idle.
    always_comb begin
        for (int unsigned k = 0; k < pairCount; k++) begin
            opA[k] = mem[2*k];
            opB[k] = mem[2*k+1];
        end
        if (phase[0]) begin
            for (int unsigned k = 0; k + 1 < pairCount; k++) begin
                opA[k] = mem[2*k+1];
                opB[k] = mem[2*k+2];
            end
        end
    end

    for (genvar k = 0; k < int'(pairCount); k++) begin : gCe
        compare_exchange #(.WIDTH(WIDTH)) uCe (
            .a  (opA[k]),
            .b  (opB[k]),
            .lo (resLo[k]),
            .hi (resHi[k])
        );
    end

    // Whole-bank result of the current phase; mem[0] and mem[N-1] hold on odd phases.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            bankNext[i] = mem[i];
        end
        if (!phase[0]) begin
            for (int unsigned k = 0; k < pairCount; k++) begin
                bankNext[2*k]   = resLo[k];
                bankNext[2*k+1] = resHi[k];
            end
        end else begin
            for (int unsigned k = 0; k + 1 < pairCount; k++) begin
                bankNext[2*k+1] = resLo[k];
                bankNext[2*k+2] = resHi[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            LOAD:    if (accept && wrIdx == lastIdx) stateNext = SORT;
            SORT:    if (lastPhase)                  stateNext = DRAIN;
            DRAIN:   if (emit && out_last)           stateNext = LOAD;
            default:                                 stateNext = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrIdx <= '0;
            phase <= '0;
            rdIdx <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wrIdx] <= in_data;
                wrIdx      <= (wrIdx == lastIdx) ? '0 : wrIdx + idxWidth'(1);
            end
            if (state == SORT) begin
                for (int unsigned i = 0; i < N; i++) begin
                    mem[i] <= bankNext[i];
                end
                phase <= lastPhase ? '0 : phase + idxWidth'(1);
            end
            if (emit) begin
                rdIdx <= out_last ? '0 : rdIdx + idxWidth'(1);
            end
        end
    end

endmodule
